idwt_1d_53: RTL
===============

# idwt_1d_53

Streaming single-level inverse 5/3 lifting wavelet transform. Accepts (low, high) coefficient pairs produced by the team's forward 1-D DWT stage and reconstructs the interleaved sample stream x[0], x[1], …, x[2N-1]. It sits on the reconstruction side of the DWT datapath and is chained once per decomposition level to undo a multi-level transform. Both sides use valid/ready handshakes, and frames are delimited by a last flag.

## Interface
- DATA_W, 8, signed width of input coefficients and output samples
- sys_clk  in  1  clock; all state updates on rising edge
- sys_rst  in  1  reset, asynchronous, active-high
- in_low  in  DATA_W  signed low-band coefficient L[n]
- in_high  in  DATA_W  signed high-band coefficient H[n]
- in_last  in  1  marks pair N-1, the final pair of the frame
- in_valid  in  1  pair present
- in_ready  out  1  pair accepted when in_valid && in_ready
- out_data  out  DATA_W  reconstructed sample
- out_last  out  1  set on x[2N-1]
- out_valid  out  1  sample present
- out_ready  in  1  sample consumed when out_valid && out_ready

## Operation
- Arithmetic: internal values are signed DATA_W+2 bits and wrap on overflow. Inputs are sign-extended. `>>>` is an arithmetic shift, so it rounds toward minus infinity.
- Even reconstruction: e[n] = L[n] - ((H[n-1] + H[n]) >>> 2), with H[-1] = H[0].
- Odd reconstruction: x[2n+1] = H[n] + ((e[n] + e[n+1]) >>> 1). At frame end the boundary is mirrored, e[N] = e[N-1], so x[2N-1] = H[N-1] + e[N-1].
- Registers:
  - prev_e: the last even value, full internal width.
  - prev_h: the last high coefficient.
  - out_e, out_o: the output pair being emitted.
  - state: the FSM state.
- States and transitions:
  - S_FIRST: in_ready=1. On accept, prev_e = L0 - ((H0+H0)>>>2) and prev_h = H0. Go to S_FL_E if in_last, else S_WAIT.
  - S_WAIT: in_ready=1. On accepting pair n:
    - e_new = L[n] - ((prev_h+H[n])>>>2)
    - out_e = prev_e
    - out_o = prev_h + ((prev_e+e_new)>>>1)
    - prev_e = e_new, prev_h = H[n]
    - Go to S_OUT_E.
  - S_OUT_E: out_valid=1 with out_data=out_e. On handshake go to S_OUT_O.
  - S_OUT_O: out_valid=1 with out_data=out_o. On handshake go to S_FL_E if the last accepted pair carried in_last, else S_WAIT.
  - S_FL_E: out_data=prev_e. On handshake go to S_FL_O.
  - S_FL_O: out_data=prev_h+prev_e and out_last=1. On handshake go to S_FIRST.
- Ready rule: in_ready=0 in every emit state. Inputs are never accepted while output is pending.
- Recursion uses only the unclamped internal values. Only the value driven on out_data is narrowed to DATA_W.
- A frame of N pairs yields exactly 2N samples, in strict index order.

## Timing
- All reset values are zero:
  - out_data = 0
  - out_valid = 0
  - out_last = 0
  - in_ready = 1 (state S_FIRST)
  - prev_e = prev_h = 0
- Latency: the pair accepted at edge t (n≥1) presents x[2n-2] on out_valid from t+1.
- Throughput: one pair per 3 cycles with out_ready held high. The final pair takes 5 cycles including the flush.
- Backpressure: while out_valid && !out_ready, out_data and out_last hold stable. There is no combinational path from out_ready to in_ready.
- in_valid is ignored in emit states, and the upstream must hold the pair.
- in_last on the first pair (N=1): S_FIRST → S_FL_E, giving 2 samples.
- Asserting sys_rst mid-frame aborts immediately. Outputs go to zero and the partial frame is discarded; there is no recovery of the in-flight samples.

## Configuration
- IDWT_SAT_EN defined: out_data is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- IDWT_SAT_EN undefined: out_data is the low DATA_W bits of the internal value (two's-complement wrap).
- The internal recursion is identical in both builds.

## Test plan
- N=1 frame, L0=10, H0=6, in_last=1 → outputs 7, 13; out_last on 13.
- N=2 frame, pairs (45,30), (50,50, last) → outputs 30, 60, 30, 80; out_last only on 80.
- Floor rounding: N=1, L0=0, H0=-3 → outputs 2, -1.
- Overflow, DATA_W=8, N=1, L0=127, H0=-128:
  - With IDWT_SAT_EN: outputs 127, 63.
  - Without IDWT_SAT_EN: outputs -65, 63.
- Backpressure: out_ready toggled randomly over a 16-pair random frame → the output sequence matches the software model. out_data is stable while stalled, and in_ready=0 in every emit state.
- Reset mid-frame: assert sys_rst during S_OUT_O of pair 3 → all outputs are 0 and in_ready=1 at once. A following N=2 frame (45,30), (50,50) reconstructs 30, 60, 30, 80.

Source files
------------

// File: rtl/idwt_1d_53.sv
`default_nettype none
// ============================================================================
// Module      : idwt_1d_53
// Description : Streaming single-level inverse 5/3 lifting wavelet transform.
//               Takes (low, high) coefficient pairs over valid/ready and emits
//               the interleaved reconstructed samples x[0..2N-1] over
//               valid/ready, with a last flag on the final sample.
//               Optional build macro: IDWT_SAT_EN (clamp out_data to the
//               signed DATA_W range instead of wrapping).
// Revision    : 1.0 - initial release
// ============================================================================
module idwt_1d_53 #(
  parameter int DATA_W = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] in_low,
  input  logic [DATA_W-1:0] in_high,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  // Two guard bits keep the lifting sums in range; recursion wraps at this width.
  localparam int IW = DATA_W + 2;

  typedef enum logic [2:0] {
    S_FIRST = 3'd0,
    S_WAIT  = 3'd1,
    S_OUT_E = 3'd2,
    S_OUT_O = 3'd3,
    S_FL_E  = 3'd4,
    S_FL_O  = 3'd5
  } state_t;

  state_t state;
  state_t next_state;

  logic signed [IW-1:0] prev_e;
  logic signed [IW-1:0] prev_h;
  logic signed [IW-1:0] out_e;
  logic signed [IW-1:0] out_o;
  logic                 last_flag;

  logic signed [IW-1:0] low_x;
  logic signed [IW-1:0] high_x;
  logic signed [IW-1:0] h_sum;
  logic signed [IW-1:0] e_new;
  logic signed [IW-1:0] e_sum;
  logic signed [IW-1:0] o_new;
  logic signed [IW-1:0] flush_o;
  logic signed [IW-1:0] emit_val;
  logic                 accept;

  assign low_x  = {{2{in_low[DATA_W-1]}}, in_low};
  assign high_x = {{2{in_high[DATA_W-1]}}, in_high};

  // The first pair mirrors its own high coefficient as H[-1].
  assign h_sum   = (state == S_FIRST) ? (high_x + high_x) : (prev_h + high_x);
  assign e_new   = low_x - (h_sum >>> 2);
  assign e_sum   = prev_e + e_new;
  assign o_new   = prev_h + (e_sum >>> 1);
  // Mirrored right boundary: (e + e) >>> 1 collapses to e.
  assign flush_o = prev_h + prev_e;

  assign accept  = in_valid && in_ready;

  // State register; asynchronous reset aborts any frame in flight.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= S_FIRST;
    end else begin
      state <= next_state;
    end
  end

  // Lifting recursion registers, updated only when a pair is accepted.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      prev_e    <= '0;
      prev_h    <= '0;
      out_e     <= '0;
      out_o     <= '0;
      last_flag <= 1'b0;
    end else if (accept) begin
      if (state == S_WAIT) begin
        out_e <= prev_e;
        out_o <= o_new;
      end
      prev_e    <= e_new;
      prev_h    <= high_x;
      last_flag <= in_last;
    end
  end

  // Next-state and handshake outputs; in_ready depends on state only.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    emit_val   = '0;
    case (state)
      S_FIRST: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state = in_last ? S_FL_E : S_WAIT;
        end
      end
      S_WAIT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state = S_OUT_E;
        end
      end
      S_OUT_E: begin
        out_valid = 1'b1;
        emit_val  = out_e;
        if (out_ready) begin
          next_state = S_OUT_O;
        end
      end
      S_OUT_O: begin
        out_valid = 1'b1;
        emit_val  = out_o;
        if (out_ready) begin
          next_state = last_flag ? S_FL_E : S_WAIT;
        end
      end
      S_FL_E: begin
        out_valid = 1'b1;
        emit_val  = prev_e;
        if (out_ready) begin
          next_state = S_FL_O;
        end
      end
      S_FL_O: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        emit_val  = flush_o;
        if (out_ready) begin
          next_state = S_FIRST;
        end
      end
      default: begin
        next_state = S_FIRST;
      end
    endcase
  end

`ifdef IDWT_SAT_EN
  localparam logic signed [IW-1:0] SAT_MAX = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [IW-1:0] SAT_MIN = {3'b111, {(DATA_W-1){1'b0}}};

  // Clamp the emitted value into the signed DATA_W range.
  always_comb begin
    out_data = emit_val[DATA_W-1:0];
    if (emit_val > SAT_MAX) begin
      out_data = SAT_MAX[DATA_W-1:0];
    end else if (emit_val < SAT_MIN) begin
      out_data = SAT_MIN[DATA_W-1:0];
    end
  end
`else
  // Two's-complement wrap: keep the low DATA_W bits.
  assign out_data = emit_val[DATA_W-1:0];
`endif

endmodule
`default_nettype wire
